// File: rtl/shift_rotate_pipe_if.sv
// Producer/consumer handshake bundle for shift_rotate_pipe: the input word with its
// shift controls and tag, and the shifted result with its tag.
interface shift_rotate_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   shift_amt;
    logic             dir;
    logic [1:0]       mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_data, shift_amt, dir, mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, shift_amt, dir, mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/shift_rotate_pipe.sv
// Pipelined barrel shifter (rotate/logical/arithmetic): SHW cycles of latency, one word per cycle.
// A single global stall freezes every stage while the held result is not taken, so in_ready = !out_valid || out_ready.
module shift_rotate_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                rst,
    shift_rotate_pipe_if.slave  bus
);

    // One power-of-two step; sh is a per-stage constant once the stage loop unrolls.
    function automatic logic [WIDTH-1:0] f_step(
        input logic [WIDTH-1:0] w,
        input int               sh,
        input logic             d,
        input logic [1:0]       m,
        input logic             sgn,
        input logic             en
    );
        logic             rot;
        logic             ari;
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] fill;
        rot  = (m == 2'b00) || (m == 2'b11);
        ari  = (m == 2'b10);
        ones = '1;
        if (!en) begin
            return w;
        end
        if (d) begin
            fill = rot ? (w >> (WIDTH - sh)) : '0;
            return (w << sh) | fill;
        end
        if (rot) begin
            fill = w << (WIDTH - sh);
        end else if (ari && sgn) begin
            fill = ~(ones >> sh);
        end else begin
            fill = '0;
        end
        return (w >> sh) | fill;
    endfunction

    logic             r_vld  [SHW];
    logic [WIDTH-1:0] r_dat  [SHW];
    logic [SHW-1:0]   r_amt  [SHW];
    logic             r_dir  [SHW];
    logic [1:0]       r_mode [SHW];
    logic             r_sgn  [SHW];
    logic [TAG_W-1:0] r_tag  [SHW];

    logic             w_src_vld  [SHW];
    logic [WIDTH-1:0] w_src_dat  [SHW];
    logic [SHW-1:0]   w_src_amt  [SHW];
    logic             w_src_dir  [SHW];
    logic [1:0]       w_src_mode [SHW];
    logic             w_src_sgn  [SHW];
    logic [TAG_W-1:0] w_src_tag  [SHW];

    logic             r_out_vld;
    logic [WIDTH-1:0] r_out_dat;
    logic [TAG_W-1:0] r_out_tag;

    logic             w_advance;

    assign w_advance     = !r_out_vld || bus.out_ready;
    assign bus.in_ready  = w_advance;
    assign bus.out_valid = r_out_vld;
    assign bus.out_data  = r_out_dat;
    assign bus.out_tag   = r_out_tag;

    // Stage k consumes the register of stage k-1; stage 0 consumes the input port.
    always_comb begin
        w_src_vld[0]  = bus.in_valid;
        w_src_dat[0]  = bus.in_data;
        w_src_amt[0]  = bus.shift_amt;
        w_src_dir[0]  = bus.dir;
        w_src_mode[0] = bus.mode;
        w_src_sgn[0]  = bus.in_data[WIDTH-1];
        w_src_tag[0]  = bus.in_tag;
        for (int k = 1; k < SHW; k++) begin
            w_src_vld[k]  = r_vld[k-1];
            w_src_dat[k]  = r_dat[k-1];
            w_src_amt[k]  = r_amt[k-1];
            w_src_dir[k]  = r_dir[k-1];
            w_src_mode[k] = r_mode[k-1];
            w_src_sgn[k]  = r_sgn[k-1];
            w_src_tag[k]  = r_tag[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SHW; k++) begin
                r_vld[k]  <= 1'b0;
                r_dat[k]  <= '0;
                r_amt[k]  <= '0;
                r_dir[k]  <= 1'b0;
                r_mode[k] <= 2'b00;
                r_sgn[k]  <= 1'b0;
                r_tag[k]  <= '0;
            end
            r_out_vld <= 1'b0;
            r_out_dat <= '0;
            r_out_tag <= '0;
        end else if (w_advance) begin
            // Bubbles advance with the data; only the valid bit marks them.
            for (int k = 0; k < SHW; k++) begin
                r_vld[k]  <= w_src_vld[k];
                r_dat[k]  <= f_step(w_src_dat[k], 1 << k, w_src_dir[k], w_src_mode[k],
                                    w_src_sgn[k], w_src_amt[k][k]);
                r_amt[k]  <= w_src_amt[k];
                r_dir[k]  <= w_src_dir[k];
                r_mode[k] <= w_src_mode[k];
                r_sgn[k]  <= w_src_sgn[k];
                r_tag[k]  <= w_src_tag[k];
            end
            r_out_vld <= r_vld[SHW-1];
            r_out_dat <= r_dat[SHW-1];
            r_out_tag <= r_tag[SHW-1];
        end
    end

endmodule

// File: tb/tb_shift_rotate_pipe.sv
// Directed table vectors plus backpressure/reset sequences on the 32-bit instance, then a
// random run on 8/32/64-bit instances against a bit-level reference model.
module tb_shift_rotate_pipe;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    shift_rotate_pipe_if #(.WIDTH(8),  .TAG_W(4)) b8 ();
    shift_rotate_pipe_if #(.WIDTH(32), .TAG_W(4)) b32 ();
    shift_rotate_pipe_if #(.WIDTH(64), .TAG_W(4)) b64 ();

    shift_rotate_pipe #(.WIDTH(8),  .TAG_W(4)) u8  (.clk(clk), .rst(rst), .bus(b8));
    shift_rotate_pipe #(.WIDTH(32), .TAG_W(4)) u32 (.clk(clk), .rst(rst), .bus(b32));
    shift_rotate_pipe #(.WIDTH(64), .TAG_W(4)) u64 (.clk(clk), .rst(rst), .bus(b64));

    // Shared stimulus; s_en selects which instances see in_valid.
    logic        s_vld;
    logic [63:0] s_dat;
    logic [5:0]  s_amt;
    logic        s_dir;
    logic [1:0]  s_mode;
    logic [3:0]  s_tag;
    logic        s_ordy;
    logic [2:0]  s_en;

    assign b8.in_valid   = s_vld && s_en[0];
    assign b8.in_data    = s_dat[7:0];
    assign b8.shift_amt  = s_amt[2:0];
    assign b8.dir        = s_dir;
    assign b8.mode       = s_mode;
    assign b8.in_tag     = s_tag;
    assign b8.out_ready  = s_ordy;

    assign b32.in_valid  = s_vld && s_en[1];
    assign b32.in_data   = s_dat[31:0];
    assign b32.shift_amt = s_amt[4:0];
    assign b32.dir       = s_dir;
    assign b32.mode      = s_mode;
    assign b32.in_tag    = s_tag;
    assign b32.out_ready = s_ordy;

    assign b64.in_valid  = s_vld && s_en[2];
    assign b64.in_data   = s_dat;
    assign b64.shift_amt = s_amt;
    assign b64.dir       = s_dir;
    assign b64.mode      = s_mode;
    assign b64.in_tag    = s_tag;
    assign b64.out_ready = s_ordy;

    logic        m_ovld [3];
    logic        m_irdy [3];
    logic [63:0] m_odat [3];
    logic [3:0]  m_otag [3];

    assign m_ovld[0] = b8.out_valid;
    assign m_ovld[1] = b32.out_valid;
    assign m_ovld[2] = b64.out_valid;
    assign m_irdy[0] = b8.in_ready;
    assign m_irdy[1] = b32.in_ready;
    assign m_irdy[2] = b64.in_ready;
    assign m_odat[0] = {56'h0, b8.out_data};
    assign m_odat[1] = {32'h0, b32.out_data};
    assign m_odat[2] = b64.out_data;
    assign m_otag[0] = b8.out_tag;
    assign m_otag[1] = b32.out_tag;
    assign m_otag[2] = b64.out_tag;

    int n_cmp;
    int n_bad;
    int n_out [3];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_shift(input logic [63:0] x, input int w, input int n,
                                              input logic d, input logic [1:0] m);
        logic [63:0] r;
        int          s;
        r = '0;
        for (int i = 0; i < w; i++) begin
            if (d) begin
                s = i - n;
                if (s >= 0) r[i] = x[s];
                else if (m == 2'b00 || m == 2'b11) r[i] = x[s + w];
            end else begin
                s = i + n;
                if (s < w) r[i] = x[s];
                else if (m == 2'b00 || m == 2'b11) r[i] = x[s - w];
                else if (m == 2'b10) r[i] = x[w - 1];
            end
        end
        return r;
    endfunction

    // Scoreboards: {tag, expected data}, one per instance.
    logic [67:0] q0 [$];
    logic [67:0] q1 [$];
    logic [67:0] q2 [$];
    logic        hold   [3];
    logic [63:0] h_dat  [3];
    logic [3:0]  h_tag  [3];

    always @(negedge clk) begin
        int          w;
        logic [63:0] msk;
        logic [67:0] ent;
        logic        empty;
        if (rst) begin
            q0.delete();
            q1.delete();
            q2.delete();
            for (int d = 0; d < 3; d++) hold[d] = 1'b0;
        end else begin
            for (int d = 0; d < 3; d++) begin
                w   = (d == 0) ? 8 : (d == 1) ? 32 : 64;
                msk = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
                if (hold[d]) begin
                    chk("hold_valid", {63'h0, m_ovld[d]}, 64'd1);
                    chk("hold_data", m_odat[d], h_dat[d]);
                    chk("hold_tag", {60'h0, m_otag[d]}, {60'h0, h_tag[d]});
                end
                hold[d]  = m_ovld[d] && !s_ordy;
                h_dat[d] = m_odat[d];
                h_tag[d] = m_otag[d];
                if (s_vld && s_en[d] && m_irdy[d]) begin
                    ent = {s_tag, ref_shift(s_dat & msk, w, int'(s_amt) & (w - 1), s_dir, s_mode)};
                    case (d)
                        0:       q0.push_back(ent);
                        1:       q1.push_back(ent);
                        default: q2.push_back(ent);
                    endcase
                end
                if (m_ovld[d] && s_ordy) begin
                    n_out[d]++;
                    empty = (d == 0) ? (q0.size() == 0) : (d == 1) ? (q1.size() == 0) : (q2.size() == 0);
                    if (empty) begin
                        chk("sb_unexpected_output", m_odat[d], 64'hDEAD_DEAD_DEAD_DEAD);
                    end else begin
                        case (d)
                            0:       ent = q0.pop_front();
                            1:       ent = q1.pop_front();
                            default: ent = q2.pop_front();
                        endcase
                        chk("sb_data", m_odat[d], ent[63:0]);
                        chk("sb_tag", {60'h0, m_otag[d]}, {60'h0, ent[67:64]});
                    end
                end
            end
        end
    end

    typedef struct {
        logic [31:0] dat;
        logic [4:0]  amt;
        logic        dir;
        logic [1:0]  mode;
        logic [31:0] exp;
    } vec_t;

    vec_t vec [13];
    int   lat;
    int   got;
    int   first;
    int   sent;
    int   base;
    logic fire;
    logic stale;

    initial begin
        vec[0]  = '{32'h18A0_0000, 5'd10, 1'b1, 2'b00, 32'h8000_0062};
        vec[1]  = '{32'h00FF_0003, 5'd20, 1'b0, 2'b00, 32'hF000_300F};
        vec[2]  = '{32'h8000_0001, 5'd4,  1'b0, 2'b01, 32'h0800_0000};
        vec[3]  = '{32'h8000_0001, 5'd4,  1'b0, 2'b10, 32'hF800_0000};
        vec[4]  = '{32'h0000_0003, 5'd31, 1'b1, 2'b10, 32'h8000_0000};
        vec[5]  = '{32'h0000_0001, 5'd1,  1'b0, 2'b11, 32'h8000_0000};
        vec[6]  = '{32'h9A5C_3E71, 5'd0,  1'b1, 2'b00, 32'h9A5C_3E71};
        vec[7]  = '{32'h9A5C_3E71, 5'd0,  1'b0, 2'b00, 32'h9A5C_3E71};
        vec[8]  = '{32'h9A5C_3E71, 5'd0,  1'b1, 2'b01, 32'h9A5C_3E71};
        vec[9]  = '{32'h9A5C_3E71, 5'd0,  1'b0, 2'b01, 32'h9A5C_3E71};
        vec[10] = '{32'h9A5C_3E71, 5'd0,  1'b1, 2'b10, 32'h9A5C_3E71};
        vec[11] = '{32'h9A5C_3E71, 5'd0,  1'b0, 2'b10, 32'h9A5C_3E71};
        vec[12] = '{32'h0000_0001, 5'd31, 1'b1, 2'b00, 32'h8000_0000};

        n_cmp = 0;
        n_bad = 0;
        for (int d = 0; d < 3; d++) n_out[d] = 0;
        s_vld = 1'b0; s_dat = '0; s_amt = '0; s_dir = 1'b0; s_mode = 2'b00;
        s_tag = '0; s_ordy = 1'b1; s_en = 3'b010;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_out_valid", {63'h0, b32.out_valid}, 64'd0);
        chk("reset_out_data", {32'h0, b32.out_data}, 64'd0);
        chk("reset_out_tag", {60'h0, b32.out_tag}, 64'd0);
        chk("reset_in_ready", {63'h0, b32.in_ready}, 64'd1);

        // Single word: latency and exact result.
        s_vld = 1'b1; s_dat = {32'h0, vec[0].dat}; s_amt = {1'b0, vec[0].amt};
        s_dir = vec[0].dir; s_mode = vec[0].mode; s_tag = 4'hA;
        @(posedge clk);
        #1 s_vld = 1'b0;
        lat = 0;
        while (!b32.out_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("latency", 64'(lat), 64'd5);
        chk("rol10_data", {32'h0, b32.out_data}, {32'h0, vec[0].exp});
        chk("rol10_tag", {60'h0, b32.out_tag}, 64'hA);
        repeat (3) @(posedge clk);
        #1;

        // Whole table back to back: one result per cycle, in order.
        got = 0;
        first = -1;
        fork
            begin
                for (int i = 0; i < 13; i++) begin
                    s_vld = 1'b1; s_dat = {32'h0, vec[i].dat}; s_amt = {1'b0, vec[i].amt};
                    s_dir = vec[i].dir; s_mode = vec[i].mode; s_tag = 4'(i);
                    @(posedge clk);
                    #1;
                end
                s_vld = 1'b0;
            end
            begin
                for (int c = 0; c < 40 && got < 13; c++) begin
                    @(negedge clk);
                    if (b32.out_valid) begin
                        if (got == 0) first = c;
                        chk("table_data", {32'h0, b32.out_data}, {32'h0, vec[got].exp});
                        chk("table_tag", {60'h0, b32.out_tag}, 64'(got));
                        chk("table_cycle", 64'(c - first), 64'(got));
                        got++;
                    end
                end
            end
        join
        chk("table_count", 64'(got), 64'd13);
        repeat (3) @(posedge clk);
        #1;

        // Ten words with a seven-cycle consumer stall mid-stream.
        sent = 0;
        base = n_out[1];
        for (int c = 0; c < 80 && !(sent == 10 && q1.size() == 0); c++) begin
            if (!s_vld && sent < 10) begin
                s_vld = 1'b1; s_dat = {32'h0, $urandom}; s_amt = 6'($urandom_range(0, 31));
                s_dir = 1'($urandom); s_mode = 2'($urandom); s_tag = 4'(sent);
            end
            s_ordy = !(c >= 7 && c < 14);
            @(negedge clk);
            fire = s_vld && b32.in_ready;
            if (c >= 7 && c < 14) chk("stall_in_ready", {63'h0, b32.in_ready}, 64'd0);
            @(posedge clk);
            #1;
            if (fire) begin
                sent++;
                s_vld = 1'b0;
            end
        end
        s_vld = 1'b0;
        s_ordy = 1'b1;
        chk("bp_delivered", 64'(n_out[1] - base), 64'd10);
        chk("bp_queue_empty", 64'(q1.size()), 64'd0);

        // Reset with three words in flight.
        for (int i = 0; i < 3; i++) begin
            s_vld = 1'b1; s_dat = {32'h0, 32'hC0DE_0000 + 32'(i)}; s_amt = 6'd3;
            s_dir = 1'b1; s_mode = 2'b01; s_tag = 4'(i + 5);
            @(posedge clk);
            #1;
        end
        s_vld = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", {63'h0, b32.out_valid}, 64'd0);
        chk("rst_out_data", {32'h0, b32.out_data}, 64'd0);
        chk("rst_in_ready", {63'h0, b32.in_ready}, 64'd1);
        stale = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (b32.out_valid) stale = 1'b1;
        end
        chk("rst_no_stale", {63'h0, stale}, 64'd0);
        @(posedge clk);
        #1;

        // Random traffic on all three widths with 50% consumer readiness.
        s_en = 3'b111;
        for (int c = 0; c < 20000; c++) begin
            s_vld = ($urandom_range(0, 3) != 0);
            s_dat = {$urandom, $urandom};
            s_amt = 6'($urandom_range(0, 63));
            s_dir = 1'($urandom);
            s_mode = 2'($urandom);
            s_tag = 4'($urandom);
            s_ordy = 1'($urandom);
            @(posedge clk);
            #1;
        end
        s_vld = 1'b0;
        s_ordy = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("drain_w8", 64'(q0.size()), 64'd0);
        chk("drain_w32", 64'(q1.size()), 64'd0);
        chk("drain_w64", 64'(q2.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
